// File: rtl/recirc_lane_source.sv
// Purpose: four-lane transmit source feeding the lane recirculator, with link bring-up FSM.
// Latency: a word pushed at edge N is poppable at N+1; outputs are registered (appear after the pop edge).
// Backpressure: pause inhibits all pops; a push to a full lane without a pop is an overflow and latches ERROR.

// Per-lane circular buffer; caller guarantees push only when space exists (or a pop occurs at the same edge).
module recirc_lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;

  // Storage array; contents are don't-care whenever the count says so, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); simultaneous push+pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

module recirc_lane_source #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic [DATA_W-1:0] wr_data3,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic              wr_en2,
  input  logic              wr_en3,
  input  logic              pause,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic [DATA_W-1:0] dataOut2,
  output logic [DATA_W-1:0] dataOut3,
  output logic              validOut0,
  output logic              validOut1,
  output logic              validOut2,
  output logic              validOut3,
  output logic              selector_IDLE,
  output logic [2:0]        state,
  output logic              error
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [INIT_W-1:0]  r_init_cnt;
  logic [INIT_W-1:0]  w_next_init_cnt;

  logic [DATA_W-1:0]  w_wr_data [4];
  logic [DATA_W-1:0]  w_head    [4];
  logic [CNT_W-1:0]   w_count   [4];
  logic [DATA_W-1:0]  r_data    [4];
  logic [3:0]         w_wr_en;
  logic [3:0]         w_full;
  logic [3:0]         w_empty;
  logic [3:0]         w_pop_raw;
  logic [3:0]         w_ovf;
  logic [3:0]         w_pop;
  logic [3:0]         w_push;
  logic [3:0]         r_valid;
  logic               w_any_ovf;
  logic               w_can_pop;
  logic               w_accepting;
  logic               r_sel;
  logic               r_error;

  assign w_wr_data[0] = wr_data0;
  assign w_wr_data[1] = wr_data1;
  assign w_wr_data[2] = wr_data2;
  assign w_wr_data[3] = wr_data3;
  assign w_wr_en      = {wr_en3, wr_en2, wr_en1, wr_en0};

  // Overflow is only meaningful once the link is out of RESET and not already latched in ERROR.
  assign w_can_pop   = (r_state == ST_ACTIVE) && !pause;
  assign w_accepting = (r_state != ST_RESET) && (r_state != ST_ERROR);
  assign w_any_ovf   = |w_ovf;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_full[g]    = (w_count[g] == CNT_W'(FIFO_DEPTH));
    assign w_empty[g]   = (w_count[g] == '0);
    assign w_pop_raw[g] = w_can_pop && !w_empty[g];
    // A full lane is only safe to write if it drains a word at the same edge.
    assign w_ovf[g]     = w_accepting && w_wr_en[g] && w_full[g] && !w_pop_raw[g];
    // On an overflow edge every lane freezes so the ERROR entry is clean (no valid outputs).
    assign w_pop[g]     = w_pop_raw[g] && !w_any_ovf;
    assign w_push[g]    = w_wr_en[g] && (r_state != ST_ERROR) && !w_any_ovf &&
                          (!w_full[g] || w_pop[g]);

    recirc_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_wdata (w_wr_data[g]),
      .o_rdata (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Next-state logic: INIT dwells INIT_CYCLES cycles; overflow overrides everything after RESET.
  always_comb begin
    w_next_state    = r_state;
    w_next_init_cnt = r_init_cnt;
    case (r_state)
      ST_RESET: begin
        w_next_state    = ST_INIT;
        w_next_init_cnt = '0;
      end
      ST_INIT: begin
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_next_state = ST_IDLE;
        else                                        w_next_init_cnt = r_init_cnt + 1'b1;
      end
      ST_IDLE: begin
        if (!(&w_empty)) w_next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if ((&w_empty) && !(|w_wr_en)) w_next_state = ST_IDLE;
      end
      ST_ERROR: begin
        w_next_state = ST_ERROR;
      end
      default: begin
        w_next_state = ST_RESET;
      end
    endcase
    if (w_any_ovf) w_next_state = ST_ERROR;
  end

  // State and INIT counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RESET;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_init_cnt <= w_next_init_cnt;
    end
  end

  // Registered lane outputs, path selector and sticky error; non-popping lanes hold their data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_sel   <= 1'b0;
      r_error <= 1'b0;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      r_valid <= w_pop;
      r_sel   <= (w_next_state == ST_IDLE) || (w_next_state == ST_ACTIVE);
      r_error <= r_error || (w_next_state == ST_ERROR);
      for (int i = 0; i < 4; i++) begin
        if (w_pop[i]) r_data[i] <= w_head[i];
      end
    end
  end

  assign full0  = w_full[0];
  assign full1  = w_full[1];
  assign full2  = w_full[2];
  assign full3  = w_full[3];
  assign empty0 = w_empty[0];
  assign empty1 = w_empty[1];
  assign empty2 = w_empty[2];
  assign empty3 = w_empty[3];

  assign dataOut0  = r_data[0];
  assign dataOut1  = r_data[1];
  assign dataOut2  = r_data[2];
  assign dataOut3  = r_data[3];
  assign validOut0 = r_valid[0];
  assign validOut1 = r_valid[1];
  assign validOut2 = r_valid[2];
  assign validOut3 = r_valid[3];

  assign selector_IDLE = r_sel;
  assign state         = r_state;
  assign error         = r_error;
endmodule

// File: tb/tb_recirc_lane_source.sv
// Purpose: self-checking bench for recirc_lane_source (bring-up, streaming, pause, wrap, full, reset).
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next rising edge.
// Backpressure: pause patterns exercised directly; flow control of writes tracked by the bench.
module tb_recirc_lane_source;
  logic        clk;
  logic        reset;
  logic        pause;
  logic [3:0]  we;
  logic [31:0] wd;

  logic [7:0]  dataOut0, dataOut1, dataOut2, dataOut3;
  logic        validOut0, validOut1, validOut2, validOut3;
  logic        full0, full1, full2, full3;
  logic        empty0, empty1, empty2, empty3;
  logic        selector_IDLE;
  logic [2:0]  state;
  logic        error;

  logic [31:0] o_d;
  logic [3:0]  o_vld;
  logic [3:0]  o_full;
  logic [3:0]  o_empty;

  int n_checks;
  int n_err;

  assign o_d     = {dataOut3, dataOut2, dataOut1, dataOut0};
  assign o_vld   = {validOut3, validOut2, validOut1, validOut0};
  assign o_full  = {full3, full2, full1, full0};
  assign o_empty = {empty3, empty2, empty1, empty0};

  recirc_lane_source #(
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .INIT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_data0      (wd[7:0]),
    .wr_data1      (wd[15:8]),
    .wr_data2      (wd[23:16]),
    .wr_data3      (wd[31:24]),
    .wr_en0        (we[0]),
    .wr_en1        (we[1]),
    .wr_en2        (we[2]),
    .wr_en3        (we[3]),
    .pause         (pause),
    .full0         (full0),
    .full1         (full1),
    .full2         (full2),
    .full3         (full3),
    .empty0        (empty0),
    .empty1        (empty1),
    .empty2        (empty2),
    .empty3        (empty3),
    .dataOut0      (dataOut0),
    .dataOut1      (dataOut1),
    .dataOut2      (dataOut2),
    .dataOut3      (dataOut3),
    .validOut0     (validOut0),
    .validOut1     (validOut1),
    .validOut2     (validOut2),
    .validOut3     (validOut3),
    .selector_IDLE (selector_IDLE),
    .state         (state),
    .error         (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        pause;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [2:0]  st;
    logic        sel;
    logic [3:0]  vld;
    logic [31:0] d;
    logic        err;
    logic [3:0]  empty;
    logic [3:0]  full;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic rst, input logic p, input logic [3:0] w,
                              input logic [31:0] wdat, input logic [2:0] st,
                              input logic sel, input logic [3:0] vld, input logic [31:0] d,
                              input logic err, input logic [3:0] emp, input logic [3:0] ful);
    vec_t v;
    v.rst = rst; v.pause = p; v.we = w; v.wd = wdat;
    v.st = st; v.sel = sel; v.vld = vld; v.d = d;
    v.err = err; v.empty = emp; v.full = ful;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int tcnt;
    logic [15:0] pat;
    logic [7:0]  wbyte;

    n_checks = 0;
    n_err    = 0;
    reset = 1'b0; pause = 1'b0; we = 4'h0; wd = 32'h0;

    // rst pause we wd | state sel vld dataOut err empty full
    tbl[0]  = mk(0,0,4'h0,32'h0,        3'd0,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[1]  = mk(0,0,4'h0,32'h0,        3'd0,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[2]  = mk(0,0,4'h0,32'h0,        3'd0,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[3]  = mk(1,0,4'h0,32'h0,        3'd1,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[4]  = mk(1,0,4'h0,32'h0,        3'd1,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[5]  = mk(1,0,4'h0,32'h0,        3'd1,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[6]  = mk(1,0,4'h0,32'h0,        3'd1,0,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[7]  = mk(1,0,4'h0,32'h0,        3'd2,1,4'h0,32'h0,        0,4'hF,4'h0);
    tbl[8]  = mk(1,0,4'h4,32'h00A50000, 3'd2,1,4'h0,32'h0,        0,4'hB,4'h0);
    tbl[9]  = mk(1,0,4'h0,32'h0,        3'd3,1,4'h0,32'h0,        0,4'hB,4'h0);
    tbl[10] = mk(1,0,4'h0,32'h0,        3'd3,1,4'h4,32'h00A50000, 0,4'hF,4'h0);
    tbl[11] = mk(1,0,4'h0,32'h0,        3'd2,1,4'h0,32'h00A50000, 0,4'hF,4'h0);
    tbl[12] = mk(1,0,4'hF,32'h01010101, 3'd2,1,4'h0,32'h00A50000, 0,4'h0,4'h0);
    tbl[13] = mk(1,0,4'hF,32'h02020202, 3'd3,1,4'h0,32'h00A50000, 0,4'h0,4'h0);
    tbl[14] = mk(1,0,4'hF,32'h03030303, 3'd3,1,4'hF,32'h01010101, 0,4'h0,4'h0);
    tbl[15] = mk(1,0,4'hF,32'h04040404, 3'd3,1,4'hF,32'h02020202, 0,4'h0,4'h0);
    tbl[16] = mk(1,1,4'h0,32'h0,        3'd3,1,4'h0,32'h02020202, 0,4'h0,4'h0);
    tbl[17] = mk(1,1,4'h0,32'h0,        3'd3,1,4'h0,32'h02020202, 0,4'h0,4'h0);
    tbl[18] = mk(1,0,4'h0,32'h0,        3'd3,1,4'hF,32'h03030303, 0,4'h0,4'h0);
    tbl[19] = mk(1,0,4'h0,32'h0,        3'd3,1,4'hF,32'h04040404, 0,4'hF,4'h0);
    tbl[20] = mk(1,0,4'h0,32'h0,        3'd2,1,4'h0,32'h04040404, 0,4'hF,4'h0);

    for (int i = 0; i < 21; i++) begin
      reset = tbl[i].rst; pause = tbl[i].pause; we = tbl[i].we; wd = tbl[i].wd;
      step();
      chk($sformatf("row%0d_state", i), {29'h0, state},         {29'h0, tbl[i].st});
      chk($sformatf("row%0d_sel", i),   {31'h0, selector_IDLE}, {31'h0, tbl[i].sel});
      chk($sformatf("row%0d_vld", i),   {28'h0, o_vld},         {28'h0, tbl[i].vld});
      chk($sformatf("row%0d_data", i),  o_d,                    tbl[i].d);
      chk($sformatf("row%0d_err", i),   {31'h0, error},         {31'h0, tbl[i].err});
      chk($sformatf("row%0d_empty", i), {28'h0, o_empty},       {28'h0, tbl[i].empty});
      chk($sformatf("row%0d_full", i),  {28'h0, o_full},        {28'h0, tbl[i].full});
    end

    // Wrap-around on lane 3: ten words through a depth-4 FIFO under a pause pattern.
    sent = 0; recv = 0; tcnt = 0;
    pat  = 16'b0011_1000_0110_0100;
    for (int c = 0; c < 80 && recv < 10; c++) begin
      logic p;
      logic w;
      p = pat[c % 16];
      w = (sent < 10) && (tcnt < 4);
      wbyte = 8'(16 + sent);
      pause = p; we = w ? 4'h8 : 4'h0; wd = {wbyte, 24'h0};
      step();
      if (p) chk("wrap_pause_vld", {31'h0, validOut3}, 32'h0);
      if (validOut3) begin
        chk("wrap_data", {24'h0, dataOut3}, 32'(16 + recv));
        recv++;
        tcnt--;
      end
      if (w) begin
        sent++;
        tcnt++;
      end
    end
    chk("wrap_count", 32'(recv), 32'd10);
    chk("wrap_empty3", {31'h0, empty3}, 32'h1);
    pause = 1'b0; we = 4'h0; wd = 32'h0;
    step();
    chk("wrap_back_idle", {29'h0, state}, 32'd2);

    // Reset in ACTIVE with three words buffered on lane 1.
    pause = 1'b1; we = 4'h2;
    for (int k = 0; k < 3; k++) begin
      wd = 32'(32'h2100 + k * 32'h100);
      step();
    end
    chk("midrst_pre_state", {29'h0, state}, 32'd3);
    chk("midrst_pre_empty1", {31'h0, empty1}, 32'h0);
    reset = 1'b0; pause = 1'b0; we = 4'h0; wd = 32'h0;
    step();
    chk("midrst_state", {29'h0, state}, 32'd0);
    chk("midrst_empty", {28'h0, o_empty}, 32'hF);
    chk("midrst_vld", {28'h0, o_vld}, 32'h0);
    chk("midrst_data", o_d, 32'h0);
    chk("midrst_err", {31'h0, error}, 32'h0);
    chk("midrst_sel", {31'h0, selector_IDLE}, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("rebringup_state", {29'h0, state}, 32'd2);
    chk("rebringup_sel", {31'h0, selector_IDLE}, 32'h1);

    // Full boundary on lane 0, then overflow into ERROR.
    pause = 1'b1; we = 4'h1;
    for (int k = 0; k < 4; k++) begin
      wd = 32'(32'h30 + k);
      step();
    end
    chk("full_full0", {31'h0, full0}, 32'h1);
    chk("full_state", {29'h0, state}, 32'd3);
    pause = 1'b0; wd = 32'h34;
    step();
    chk("full_wrpop_err", {31'h0, error}, 32'h0);
    chk("full_wrpop_state", {29'h0, state}, 32'd3);
    chk("full_wrpop_full0", {31'h0, full0}, 32'h1);
    chk("full_wrpop_vld0", {31'h0, validOut0}, 32'h1);
    chk("full_wrpop_data0", {24'h0, dataOut0}, 32'h30);
    pause = 1'b1; wd = 32'h35;
    step();
    chk("ovf_state", {29'h0, state}, 32'd4);
    chk("ovf_err", {31'h0, error}, 32'h1);
    chk("ovf_sel", {31'h0, selector_IDLE}, 32'h0);
    chk("ovf_vld", {28'h0, o_vld}, 32'h0);
    pause = 1'b0; wd = 32'h36;
    step();
    chk("err_hold_state", {29'h0, state}, 32'd4);
    chk("err_hold_vld", {28'h0, o_vld}, 32'h0);
    chk("err_hold_err", {31'h0, error}, 32'h1);
    reset = 1'b0; we = 4'h0; wd = 32'h0;
    step();
    chk("err_rst_state", {29'h0, state}, 32'd0);
    chk("err_rst_err", {31'h0, error}, 32'h0);
    chk("err_rst_empty", {28'h0, o_empty}, 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/recirc_lane_source.md
# recirc_lane_source

Four-lane transmit source that drives the data/valid inputs and the `selector_IDLE` control of the lane recirculator. It buffers words per lane in small FIFOs and sequences link bring-up with a RESET/INIT/IDLE/ACTIVE/ERROR state machine. It issues one word per non-empty lane per cycle while active. It sits between the probe/stimulus side and the recirculator, on the transmit end of the same lane interface.

## Interface
Parameters:
- DATA_W, 8, lane word width
- FIFO_DEPTH, 4, words per lane FIFO (power of 2, ≥2)
- INIT_CYCLES, 4, cycles spent in INIT before IDLE (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- wr_data0..wr_data3  in  DATA_W  write data, lane 0..3
- wr_en0..wr_en3  in  1  push request, lane 0..3
- pause  in  1  downstream backpressure; inhibits pops
- full0..full3  out  1  lane FIFO full (count == FIFO_DEPTH)
- empty0..empty3  out  1  lane FIFO empty (count == 0)
- dataOut0..dataOut3  out  DATA_W  registered lane data to recirculator dataIn0..3
- validOut0..validOut3  out  1  registered lane valid to recirculator validIn0..3
- selector_IDLE  out  1  registered; 1 in IDLE/ACTIVE (forward path), 0 otherwise (return-to-probe path)
- state  out  3  current FSM state
- error  out  1  sticky overflow flag

## Operation
- Reset (reset==0 at an edge): all FIFOs cleared (pointers, counts = 0); dataOut*=0, validOut*=0, selector_IDLE=0, state=RESET, error=0; full*=0, empty*=1. Applies from any state, including mid-burst; buffered data is discarded.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET → INIT on the first edge with reset==1; the INIT counter loads 0.
- INIT: counts edges; → IDLE on the edge where the counter reaches INIT_CYCLES-1. Writes are accepted in INIT. No pops occur in INIT.
- IDLE → ACTIVE on an edge where any lane FIFO is non-empty (registered counts).
- ACTIVE → IDLE on an edge where all lane FIFOs are empty and no write occurs at that edge.
- Any state except RESET → ERROR on overflow: wr_enN==1 while fullN==1 and no pop on lane N at the same edge. The overflowing word is dropped.
- ERROR: error=1; selector_IDLE=0; validOut*=0; no pops; writes ignored. Only reset exits ERROR.
- Pop rule: in ACTIVE with pause==0, each lane with count>0 pops one word at the edge. dataOutN takes the word and validOutN=1.
- Lanes that do not pop at an edge: validOutN=0 and dataOutN holds its last value.
- Lanes are independent; there is no cross-lane alignment.
- Write and pop on the same lane at the same edge: both occur; the count is unchanged; this is legal even when full.
- Write to an empty FIFO in ACTIVE: the word is poppable at the next edge (no bypass).
- Pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.
- full*/empty* are combinational from the registered counts.
- selector_IDLE and state are registered; selector_IDLE updates at the same edge as the state change.

## Timing
- Reset release to IDLE: INIT_CYCLES+1 edges after the first edge with reset==1. selector_IDLE rises with that transition.
- Write latency:
  - In ACTIVE, a word written at edge N appears on dataOut/validOut after edge N+1.
  - From IDLE, a word written at edge N gives ACTIVE at N+1 and output after edge N+2.
- Throughput: one word per lane per cycle in ACTIVE with pause==0.
- pause asserted before edge N: no pop at N, and validOut*=0 after N. Data is retained.
- Overflow at edge N: state=ERROR, error=1, selector_IDLE=0 and validOut*=0 after edge N.

## Test plan
- Bring-up: hold reset=0 for 3 cycles, then release with INIT_CYCLES=4. Required: state goes 0→1, then 2 after 5 edges; selector_IDLE=1 from entering IDLE; all outputs are 0 before that.
- Single word: in IDLE, write 0xA5 on lane 2 at edge N. Required: state=ACTIVE after N+1; dataOut2=0xA5 and validOut2=1 after N+2 only; state=IDLE after N+3.
- Streaming and pause:
  - Write 0x01..0x04 to all lanes back-to-back in ACTIVE; each lane outputs 01,02,03,04 on consecutive cycles.
  - Assert pause for 2 cycles mid-stream; validOut*=0 for those 2 cycles, then the stream resumes in order with nothing lost.
- Full boundary: with pause=1, write 4 words to lane 0, so full0=1. Write and release pause at the same edge: no error, and count stays 4. Write again with pause=1: state=ERROR, error=1, selector_IDLE=0.
- Wrap-around: push and pop 10 words (0x10..0x19) on lane 3 with mixed pause. Required: output order is exact, and empty3=1 at the end.
- Reset mid-operation: drive reset=0 while in ACTIVE with 3 words buffered. Required: after that edge all FIFOs are empty, validOut*=0, dataOut*=0, state=RESET, error=0.
